pixel_scaler: RTL



---
 rtl/pixel_scaler_pkg.sv | 28 ++
 rtl/pixel_scaler_pipe_delay.sv | 30 +++
 rtl/pixel_scaler.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/pixel_scaler_pkg.sv
// Shared constants, helpers and the stage-1 counter bundle for pixel_scaler.
// No ports: imported by pixel_scaler and pipe_delay.
package pixel_scaler_pkg;

    localparam int DEF_SRC_W     = 240;
    localparam int DEF_SRC_H     = 320;
    localparam int DEF_PIX_W     = 16;
    localparam int DEF_MAX_SCALE = 4;

    // Counter field widths, sized with headroom above the default frame.
    localparam int SUB_W = 4;
    localparam int X_W   = 11;
    localparam int Y_W   = 10;
    localparam int LB_W  = 20;

    function automatic int addr_w(input int w, input int h);
        return (w * h > 1) ? $clog2(w * h) : 1;
    endfunction

    typedef struct packed {
        logic [SUB_W-1:0] hsub;
        logic [X_W-1:0]   src_x;
        logic [SUB_W-1:0] vsub;
        logic [Y_W-1:0]   src_y;
        logic [LB_W-1:0]  line_base;
    } cnt_t;

endpackage

// File: rtl/pixel_scaler_pipe_delay.sv
// pipe_delay: fixed-depth shift register, cleared to zero by async reset.
// Ports: clk_in, rst_n_in, d_in[WIDTH], q_out[WIDTH] = d_in delayed DEPTH cycles.
import pixel_scaler_pkg::*;

module pipe_delay #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 1
) (
    input  logic             clk_in,
    input  logic             rst_n_in,
    input  logic [WIDTH-1:0] d_in,
    output logic [WIDTH-1:0] q_out
);

    logic [DEPTH-1:0][WIDTH-1:0] r_sh;

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_sh <= '0;
        end else begin
            r_sh[0] <= d_in;
            for (int i = 1; i < DEPTH; i++) begin
                r_sh[i] <= r_sh[i-1];
            end
        end
    end

    assign q_out = r_sh[DEPTH-1];

endmodule

// File: rtl/pixel_scaler.sv
// pixel_scaler: integer-scale camera window upscaler with counter-based
// frame-buffer addressing and latency-matched timing/pixel outputs.
// Ports: clk_in, rst_n_in, scale_in (S-1), hcount_in, vcount_in,
//   frame_buff_in -> addr_out, hcount_out, vcount_out, cam_out, in_window_out.
// Option: define PIXEL_SCALER_MIRROR_EN to add mirror_in (horizontal mirror).
import pixel_scaler_pkg::*;

module pixel_scaler #(
    parameter int               SRC_W       = DEF_SRC_W,
    parameter int               SRC_H       = DEF_SRC_H,
    parameter int               MAX_SCALE   = DEF_MAX_SCALE,
    parameter int               PIX_W       = DEF_PIX_W,
    parameter int               RAM_LATENCY = 2,
    parameter logic [PIX_W-1:0] BG_COLOR    = 16'h0000
) (
    input  logic                               clk_in,
    input  logic                               rst_n_in,
    input  logic [$clog2(MAX_SCALE)-1:0]       scale_in,
`ifdef PIXEL_SCALER_MIRROR_EN
    input  logic                               mirror_in,
`endif
    input  logic [10:0]                        hcount_in,
    input  logic [9:0]                         vcount_in,
    input  logic [PIX_W-1:0]                   frame_buff_in,
    output logic [addr_w(SRC_W, SRC_H)-1:0]    addr_out,
    output logic [10:0]                        hcount_out,
    output logic [9:0]                         vcount_out,
    output logic [PIX_W-1:0]                   cam_out,
    output logic                               in_window_out
);

    localparam int AW  = addr_w(SRC_W, SRC_H);
    localparam int LAT = RAM_LATENCY + 2;

    localparam logic [X_W-1:0]   C_W     = X_W'(SRC_W);
    localparam logic [X_W-1:0]   C_WM1   = X_W'(SRC_W - 1);
    localparam logic [Y_W-1:0]   C_H     = Y_W'(SRC_H);
    localparam logic [Y_W-1:0]   C_HM1   = Y_W'(SRC_H - 1);
    localparam logic [LB_W-1:0]  C_LSTEP = LB_W'(SRC_W);
    localparam logic [SUB_W-1:0] C_SMAX  = SUB_W'(MAX_SCALE - 1);

    cnt_t             r_cnt;
    cnt_t             w_cnt_nxt;
    logic [SUB_W-1:0] r_smax;
    logic [SUB_W-1:0] w_req;
    logic [SUB_W-1:0] w_smax_nxt;
    logic             r_synced;
    logic             r_mirror;
    logic [PIX_W-1:0] r_fb;
    logic             w_frame;
    logic             w_line;
    logic             w_win;
    logic             w_win_d;
    logic [X_W-1:0]   w_xc;
    logic [X_W-1:0]   w_xa;
    logic [20:0]      w_pos_d;

    assign w_frame    = (hcount_in == '0) && (vcount_in == '0);
    assign w_line     = (hcount_in == '0) && (vcount_in != '0);
    assign w_req      = SUB_W'(scale_in);
    assign w_smax_nxt = (w_req > C_SMAX) ? C_SMAX : w_req;

    // r_smax holds S-1, so sub-counters wrap when they equal it.
    always_comb begin
        w_cnt_nxt = r_cnt;
        if (w_frame) begin
            w_cnt_nxt = '0;
        end else if (w_line) begin
            w_cnt_nxt.hsub  = '0;
            w_cnt_nxt.src_x = '0;
            if (r_cnt.vsub == r_smax) begin
                w_cnt_nxt.vsub = '0;
                if (r_cnt.src_y != C_H) begin
                    w_cnt_nxt.src_y = r_cnt.src_y + 1'b1;
                end
                // Base parks on the last source line so the clamped
                // address stays inside the frame buffer below the window.
                if (r_cnt.src_y < C_HM1) begin
                    w_cnt_nxt.line_base = r_cnt.line_base + C_LSTEP;
                end
            end else begin
                w_cnt_nxt.vsub = r_cnt.vsub + 1'b1;
            end
        end else begin
            if (r_cnt.hsub == r_smax) begin
                w_cnt_nxt.hsub = '0;
                if (r_cnt.src_x != C_W) begin
                    w_cnt_nxt.src_x = r_cnt.src_x + 1'b1;
                end
            end else begin
                w_cnt_nxt.hsub = r_cnt.hsub + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_cnt    <= '0;
            r_smax   <= '0;
            r_synced <= 1'b0;
            r_mirror <= 1'b0;
            r_fb     <= '0;
        end else begin
            r_cnt <= w_cnt_nxt;
            r_fb  <= frame_buff_in;
            if (w_frame) begin
                r_smax   <= w_smax_nxt;
                r_synced <= 1'b1;
`ifdef PIXEL_SCALER_MIRROR_EN
                r_mirror <= mirror_in;
`else
                r_mirror <= 1'b0;
`endif
            end
        end
    end

    assign w_win = r_synced && (r_cnt.src_x < C_W) && (r_cnt.src_y < C_H);
    assign w_xc  = (r_cnt.src_x < C_W) ? r_cnt.src_x : C_WM1;
    assign w_xa  = (r_mirror && w_win) ? (C_WM1 - r_cnt.src_x) : w_xc;

    assign addr_out = AW'(r_cnt.line_base) + AW'(w_xa);

    pipe_delay #(
        .WIDTH(21),
        .DEPTH(LAT)
    ) u_pos_dly (
        .clk_in  (clk_in),
        .rst_n_in(rst_n_in),
        .d_in    ({hcount_in, vcount_in}),
        .q_out   (w_pos_d)
    );

    pipe_delay #(
        .WIDTH(1),
        .DEPTH(RAM_LATENCY + 1)
    ) u_win_dly (
        .clk_in  (clk_in),
        .rst_n_in(rst_n_in),
        .d_in    (w_win),
        .q_out   (w_win_d)
    );

    assign hcount_out    = w_pos_d[20:10];
    assign vcount_out    = w_pos_d[9:0];
    assign in_window_out = w_win_d;
    assign cam_out       = w_win_d ? r_fb : BG_COLOR;

endmodule
